// File: rtl/hdmi_tmds_pkg.sv
// Shared TMDS constants, pipeline record types and popcount helper.
// Used by the encoder, its q_m stage and the reference decoder model.
package hdmi_tmds_pkg;

    localparam int LAT   = 4;
    localparam int CNT_W = 5;

    // Control symbols indexed by {C1,C0}
    localparam logic [9:0] CTL_CODE [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    localparam logic [9:0] GB_CODE_02   = 10'h2CC;
    localparam logic [9:0] GB_CODE_1    = 10'h133;

    typedef struct packed {
        logic       de;
        logic [1:0] ctl;
        logic [7:0] data;
    } pix_t;

    typedef struct packed {
        logic       de;
        logic [1:0] ctl;
        logic [8:0] qm;
        logic [3:0] n1;
        logic [3:0] n0;
    } qm_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + 4'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/hdmi_tmds_encode_if.sv
// Pixel-side bundle of one TMDS channel: ce/de/ctl/data in, symbol and valid out.
// No clock inside; the encoder takes clock and reset as plain ports.
interface hdmi_tmds_encode_if;
    logic       i_ce;
    logic       i_de;
    logic [1:0] i_ctl;
    logic [7:0] i_data;
    logic [9:0] o_word;
    logic       o_valid;

    modport master (output i_ce, i_de, i_ctl, i_data, input o_word, o_valid);
    modport slave  (input i_ce, i_de, i_ctl, i_data, output o_word, o_valid);
endinterface

// File: rtl/tmds_qm_stage.sv
// Combinational TMDS transition-minimising stage: q_m[8:0] plus popcounts of q_m[7:0].
// Zero latency, no flow control; shared with the TMDS decoder model.
module tmds_qm_stage
    import hdmi_tmds_pkg::*;
(
    input  logic [7:0] data_i,
    output logic [8:0] qm_o,
    output logic [3:0] n1_o,
    output logic [3:0] n0_o
);

    logic [3:0] n1_data;
    logic       use_xnor;
    logic [8:0] qm;

    always_comb begin
        n1_data  = popcount8(data_i);
        use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data_i[0]);
        qm       = '0;
        qm[0]    = data_i[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ data_i[i]) : (qm[i-1] ^ data_i[i]);
        end
        qm[8] = ~use_xnor;
        qm_o  = qm;
        n1_o  = popcount8(qm[7:0]);
        n0_o  = 4'd8 - n1_o;
    end

endmodule

// File: rtl/hdmi_tmds_encode.sv
// Per-channel TMDS encoder with running disparity and optional HDMI video guard band.
// Latency 4 accepted beats; i_ce=0 freezes every register (no backpressure output).
module hdmi_tmds_encode
    import hdmi_tmds_pkg::*;
#(
    parameter int CHANNEL    = 0,
    parameter bit GUARD_BAND = 1'b0
)
(
    input  logic               i_clk,
    input  logic               i_reset_n,
    hdmi_tmds_encode_if.slave  bus
);

    localparam int BW = $clog2(LAT);
    localparam logic [9:0] GB_CODE = (CHANNEL == 1) ? GB_CODE_1 : GB_CODE_02;
    localparam logic signed [CNT_W-1:0] TWO = CNT_W'(2);

    pix_t                    s1_q, s1_d;
    qm_t                     s2_q, s2_d;
    logic [9:0]              word3_q, word3_d;
    logic [9:0]              word_q, word_d;
    logic signed [CNT_W-1:0] cnt_q, cnt_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic                    valid_q, valid_d;

    logic [8:0]              qm;
    logic [3:0]              n1, n0;
    logic signed [CNT_W-1:0] n1_s, n0_s;
    logic                    q8, cnt_pos, cnt_neg, gb_ahead;
    logic [7:0]              qm8;

    tmds_qm_stage u_qm (
        .data_i (s1_q.data),
        .qm_o   (qm),
        .n1_o   (n1),
        .n0_o   (n0)
    );

    always_comb begin
        s1_d   = '{de: bus.i_de, ctl: bus.i_ctl, data: bus.i_data};
        s2_d   = '{de: s1_q.de, ctl: s1_q.ctl, qm: qm, n1: n1, n0: n0};
        word_d = word3_q;
    end

    // Lookahead: s1 holds the next symbol, the live input is the one after it.
    always_comb begin
        word3_d  = word3_q;
        cnt_d    = cnt_q;
        n1_s     = signed'({1'b0, s2_q.n1});
        n0_s     = signed'({1'b0, s2_q.n0});
        q8       = s2_q.qm[8];
        qm8      = s2_q.qm[7:0];
        cnt_neg  = cnt_q[CNT_W-1];
        cnt_pos  = !cnt_q[CNT_W-1] && (cnt_q != '0);
        gb_ahead = s1_q.de || bus.i_de;
        if (!s2_q.de) begin
            cnt_d   = '0;
            word3_d = (GUARD_BAND && gb_ahead) ? GB_CODE : CTL_CODE[s2_q.ctl];
        end else if ((cnt_q == '0) || (s2_q.n1 == s2_q.n0)) begin
            word3_d = {~q8, q8, q8 ? qm8 : ~qm8};
            cnt_d   = cnt_q + (q8 ? (n1_s - n0_s) : (n0_s - n1_s));
        end else if ((cnt_pos && (s2_q.n1 > s2_q.n0)) || (cnt_neg && (s2_q.n0 > s2_q.n1))) begin
            word3_d = {1'b1, q8, ~qm8};
            cnt_d   = cnt_q + (q8 ? TWO : '0) + n0_s - n1_s;
        end else begin
            word3_d = {1'b0, q8, qm8};
            cnt_d   = cnt_q - (q8 ? '0 : TWO) + n1_s - n0_s;
        end
    end

    always_comb begin
        beat_d  = beat_q;
        valid_d = valid_q;
        if (!valid_q) begin
            beat_d = beat_q + BW'(1);
            if (beat_q == BW'(LAT - 1)) begin
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            word3_q <= CTL_CODE[0];
            word_q  <= CTL_CODE[0];
            cnt_q   <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
        end else if (bus.i_ce) begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            word3_q <= word3_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
        end
    end

    assign bus.o_word  = word_q;
    assign bus.o_valid = valid_q;

endmodule

// File: tb/tb_hdmi_tmds_encode.sv
// Scoreboard bench for three encoder flavours (plain ch0, guard-band ch1, guard-band ch0)
// fed identical directed pixel/control vectors with hand-computed symbols.
module tb_hdmi_tmds_encode;

    logic       clk;
    logic       rst_n;
    logic       ce, de;
    logic [1:0] ctl;
    logic [7:0] data;

    hdmi_tmds_encode_if if_a ();
    hdmi_tmds_encode_if if_b ();
    hdmi_tmds_encode_if if_c ();

    assign if_a.i_ce = ce;  assign if_a.i_de = de;  assign if_a.i_ctl = ctl;  assign if_a.i_data = data;
    assign if_b.i_ce = ce;  assign if_b.i_de = de;  assign if_b.i_ctl = ctl;  assign if_b.i_data = data;
    assign if_c.i_ce = ce;  assign if_c.i_de = de;  assign if_c.i_ctl = ctl;  assign if_c.i_data = data;

    hdmi_tmds_encode #(.CHANNEL(0), .GUARD_BAND(1'b0)) dut_a (.i_clk(clk), .i_reset_n(rst_n), .bus(if_a));
    hdmi_tmds_encode #(.CHANNEL(1), .GUARD_BAND(1'b1)) dut_b (.i_clk(clk), .i_reset_n(rst_n), .bus(if_b));
    hdmi_tmds_encode #(.CHANNEL(0), .GUARD_BAND(1'b1)) dut_c (.i_clk(clk), .i_reset_n(rst_n), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       de;
        logic [1:0] ctl;
        logic [7:0] data;
        logic [9:0] ea;
        logic [9:0] eb;
        logic [9:0] ec;
    } vec_t;

    // Expected symbols: ea plain, eb guard band ch1, ec guard band ch0.
    localparam int NV = 17;
    localparam vec_t VECS [NV] = '{
        '{1'b0, 2'd0, 8'h00, 10'h354, 10'h354, 10'h354},
        '{1'b0, 2'd1, 8'h00, 10'h0AB, 10'h0AB, 10'h0AB},
        '{1'b0, 2'd2, 8'h00, 10'h154, 10'h154, 10'h154},
        '{1'b0, 2'd3, 8'h00, 10'h2AB, 10'h2AB, 10'h2AB},
        '{1'b0, 2'd0, 8'h00, 10'h354, 10'h354, 10'h354},
        '{1'b0, 2'd0, 8'h00, 10'h354, 10'h133, 10'h2CC},
        '{1'b0, 2'd0, 8'h00, 10'h354, 10'h133, 10'h2CC},
        '{1'b1, 2'd0, 8'h00, 10'h100, 10'h100, 10'h100},
        '{1'b1, 2'd0, 8'h00, 10'h3FF, 10'h3FF, 10'h3FF},
        '{1'b1, 2'd0, 8'hFF, 10'h200, 10'h200, 10'h200},
        '{1'b1, 2'd0, 8'h00, 10'h3FF, 10'h3FF, 10'h3FF},
        '{1'b0, 2'd0, 8'h00, 10'h354, 10'h133, 10'h2CC},
        '{1'b1, 2'd0, 8'hFE, 10'h2FF, 10'h2FF, 10'h2FF},
        '{1'b0, 2'd1, 8'h00, 10'h0AB, 10'h0AB, 10'h0AB},
        '{1'b0, 2'd0, 8'h00, 10'h354, 10'h354, 10'h354},
        '{1'b0, 2'd0, 8'h00, 10'h354, 10'h354, 10'h354},
        '{1'b0, 2'd0, 8'h00, 10'h354, 10'h354, 10'h354}
    };

    logic [9:0] qa [$];
    logic [9:0] qb [$];
    logic [9:0] qc [$];
    int n_cmp = 0;
    int n_err = 0;
    int ia = 0, ib = 0, ic = 0;

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endfunction

    task automatic issue(input logic d, input logic [1:0] c, input logic [7:0] x, input bit push,
                         input logic [9:0] ea, input logic [9:0] eb, input logic [9:0] ec,
                         input int unsigned idle_max);
        int unsigned idle;
        idle = $urandom_range(idle_max, 0);
        repeat (idle) begin
            @(negedge clk);
            ce   = 1'b0;
            de   = 1'($urandom);
            ctl  = 2'($urandom);
            data = 8'($urandom);
        end
        @(negedge clk);
        ce = 1'b1; de = d; ctl = c; data = x;
        if (push) begin
            qa.push_back(ea);
            qb.push_back(eb);
            qc.push_back(ec);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (((qa.size() + qb.size() + qc.size()) != 0) && (n < 40)) begin
            @(negedge clk);
            ce = 1'b1; de = 1'b0; ctl = 2'd0; data = 8'($urandom);
            n++;
        end
        @(negedge clk);
        ce = 1'b0;
        chk("left_a", qa.size(), 0);
        chk("left_b", qb.size(), 0);
        chk("left_c", qc.size(), 0);
    endtask

    // Monitor: one symbol per accepted beat while o_valid is high.
    initial begin
        logic       took;
        logic [9:0] e;
        forever begin
            @(posedge clk);
            took = ce && rst_n;
            #1;
            if (took && rst_n) begin
                if (if_a.o_valid && qa.size() > 0) begin
                    e = qa.pop_front();
                    chk($sformatf("sym_a[%0d]", ia), if_a.o_word, e);
                    ia++;
                end
                if (if_b.o_valid && qb.size() > 0) begin
                    e = qb.pop_front();
                    chk($sformatf("sym_b[%0d]", ib), if_b.o_word, e);
                    ib++;
                end
                if (if_c.o_valid && qc.size() > 0) begin
                    e = qc.pop_front();
                    chk($sformatf("sym_c[%0d]", ic), if_c.o_word, e);
                    ic++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; ce = 1'b0; de = 1'b0; ctl = 2'd0; data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_word_a", if_a.o_word, 10'h354);
        chk("rst_word_b", if_b.o_word, 10'h354);
        chk("rst_word_c", if_c.o_word, 10'h354);
        chk("rst_valid_a", if_a.o_valid, 1'b0);
        chk("rst_valid_b", if_b.o_valid, 1'b0);
        chk("rst_valid_c", if_c.o_valid, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            issue(VECS[i].de, VECS[i].ctl, VECS[i].data, 1'b1,
                  VECS[i].ea, VECS[i].eb, VECS[i].ec, (i < 4) ? 0 : 2);
            if (i == 2 || i == 3) begin
                @(posedge clk);
                #1;
                chk($sformatf("valid_beat%0d", i + 1), if_a.o_valid, (i == 3));
            end
        end
        drain();

        // Build up nonzero disparity mid-line, then reset asynchronously.
        repeat (4) issue(1'b1, 2'd0, 8'h00, 1'b0, 10'h0, 10'h0, 10'h0, 0);
        @(negedge clk);
        ce = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("snap_word_a", if_a.o_word, 10'h354);
        chk("snap_word_b", if_b.o_word, 10'h354);
        chk("snap_word_c", if_c.o_word, 10'h354);
        chk("snap_valid_a", if_a.o_valid, 1'b0);
        chk("snap_valid_b", if_b.o_valid, 1'b0);
        chk("snap_valid_c", if_c.o_valid, 1'b0);
        qa.delete(); qb.delete(); qc.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(1'b1, 2'd0, 8'h00, 1'b1, 10'h100, 10'h100, 10'h100, 1);
        issue(1'b1, 2'd0, 8'h00, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
